// File: rtl/mac_result_collector.sv
// mac_result_collector: buffers completed mac results in a FIFO, tracks job length,
// flags dropped results and stalled mac, and pulses done once the job is drained.
`default_nettype none

module mac_result_collector #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_LINES     = 5,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_LINES:0]   expected_i,
  input  logic [DATA_WIDTH-1:0] result_i,
  input  logic                  result_valid_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [ADDR_LINES:0]   count_o,
  output logic [ADDR_LINES:0]   received_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic                  timeout_o
);

  localparam int CW    = ADDR_LINES + 1;
  localparam int DEPTH = 2 ** ADDR_LINES;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   RECV_MAX = '1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_LINES-1:0] wr_ptr;
  logic [ADDR_LINES-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         received;
  logic [CW-1:0]         expected_len;
  logic [WD_W-1:0]       wd_cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic                  timeout;

  logic                  rd_accept;
  logic                  wr_accept;
  logic                  drop;
  logic [CW-1:0]         recv_next;

  assign rd_accept = rd_en_i && (count != '0);
  // A full FIFO still accepts a write when a read frees the head slot this cycle.
  assign wr_accept = result_valid_i && (state == COLLECT) && ((count != DEPTH_C) || rd_accept);
  assign drop      = result_valid_i && (state == COLLECT) && !wr_accept;
  assign recv_next = (received == RECV_MAX) ? received : received + 1'b1;

  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem[wr_ptr] <= result_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      expected_len <= '0;
      received     <= '0;
      wd_cnt       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && (expected_i != '0)) begin
            expected_len <= expected_i;
            received     <= '0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            wd_cnt       <= '0;
            busy         <= 1'b1;
            state        <= COLLECT;
          end
        end
        COLLECT: begin
          if (result_valid_i) begin
            received <= recv_next;
            wd_cnt   <= '0;
            if (drop) begin
              overflow <= 1'b1;
            end
            if (recv_next == expected_len) begin
              state <= DRAIN;
            end
          end else if (WD_EN) begin
            if (wd_cnt == WD_LAST) begin
              timeout <= 1'b1;
              state   <= DRAIN;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (count == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign rd_data_o  = rd_data;
  assign rd_valid_o = rd_valid;
  assign empty_o    = (count == '0);
  assign full_o     = (count == DEPTH_C);
  assign count_o    = count;
  assign received_o = received;
  assign busy_o     = busy;
  assign done_o     = done;
  assign overflow_o = overflow;
  assign timeout_o  = timeout;

endmodule

`default_nettype wire

// File: tb/tb_mac_result_collector.sv
// tb_mac_result_collector: directed vector table for a normal job plus hand-written
// sequences for overflow, full-with-read, watchdog timeout and mid-job reset.
`default_nettype none

module tb_mac_result_collector;

  localparam int DW = 32;
  localparam int AL = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AL:0]   expected;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AL:0]   count;
  logic [AL:0]   received;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          timeout;

  int tests = 0;
  int fails = 0;

  mac_result_collector #(
    .DATA_WIDTH    (DW),
    .ADDR_LINES    (AL),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .expected_i    (expected),
    .result_i      (result),
    .result_valid_i(result_valid),
    .rd_en_i       (rd_en),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .empty_o       (empty),
    .full_o        (full),
    .count_o       (count),
    .received_o    (received),
    .busy_o        (busy),
    .done_o        (done),
    .overflow_o    (overflow),
    .timeout_o     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic [AL:0]   exp_len;
    logic [DW-1:0] res;
    logic          rv;
    logic          rd;
    logic          e_rd_valid;
    logic [DW-1:0] e_rd_data;
    logic [AL:0]   e_count;
    logic [AL:0]   e_received;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic [AL:0] e, input logic [DW-1:0] r,
                              input logic v, input logic rd_r, input logic erv,
                              input logic [DW-1:0] ed, input logic [AL:0] ec,
                              input logic [AL:0] er, input logic eb, input logic edn);
    vec_t t;
    t.start = s; t.exp_len = e; t.res = r; t.rv = v; t.rd = rd_r;
    t.e_rd_valid = erv; t.e_rd_data = ed; t.e_count = ec; t.e_received = er;
    t.e_busy = eb; t.e_done = edn;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic s, input logic [AL:0] e, input logic [DW-1:0] r,
                       input logic v, input logic rd_r);
    start = s; expected = e; result = r; result_valid = v; rd_en = rd_r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic s, input logic [AL:0] e, input logic [DW-1:0] r,
                     input logic v, input logic rd_r);
    drive(s, e, r, v, rd_r);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Asynchronous reset asserted between edges, checked before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("reset empty", empty, 1);
    chk("reset count", count, 0);
    chk("reset busy", busy, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset done", done, 0);
    chk("reset overflow", overflow, 0);
    chk("reset timeout", timeout, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset full", full, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Normal job: start, three results spaced 5 cycles, three reads.
    add(1, 6'd0, 0,            0, 0, 0, 0,            0, 0, 0, 0);
    add(1, 6'd3, 0,            0, 0, 0, 0,            0, 0, 1, 0);
    add(0, 0,    32'hC0A00000, 1, 0, 0, 0,            1, 1, 1, 0);
    add(0, 0,    0,            0, 0, 0, 0,            1, 1, 1, 0);
    add(1, 6'd5, 0,            0, 0, 0, 0,            1, 1, 1, 0);
    add(0, 0,    0,            0, 0, 0, 0,            1, 1, 1, 0);
    add(0, 0,    0,            0, 0, 0, 0,            1, 1, 1, 0);
    add(0, 0,    32'hC094F72D, 1, 0, 0, 0,            2, 2, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 0, 0, 2, 2, 1, 0);
    add(0, 0,    32'hC089EE59, 1, 0, 0, 0,            3, 3, 1, 0);
    add(0, 0,    0,            0, 1, 1, 32'hC0A00000, 2, 3, 1, 0);
    add(0, 0,    0,            0, 1, 1, 32'hC094F72D, 1, 3, 1, 0);
    add(0, 0,    0,            0, 1, 1, 32'hC089EE59, 0, 3, 1, 0);
    add(0, 0,    0,            0, 0, 0, 32'hC089EE59, 0, 3, 0, 1);
    add(0, 0,    0,            0, 0, 0, 32'hC089EE59, 0, 3, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].exp_len, vecs[i].res, vecs[i].rv, vecs[i].rd);
      step();
      chk($sformatf("row%0d rd_valid", i), rd_valid, vecs[i].e_rd_valid);
      chk($sformatf("row%0d rd_data", i), rd_data, vecs[i].e_rd_data);
      chk($sformatf("row%0d count", i), count, vecs[i].e_count);
      chk($sformatf("row%0d received", i), received, vecs[i].e_received);
      chk($sformatf("row%0d busy", i), busy, vecs[i].e_busy);
      chk($sformatf("row%0d done", i), done, vecs[i].e_done);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Overflow: 33 results, no reads.
    cyc(1, 6'd33, 0, 0, 0);
    chk("ovf start busy", busy, 1);
    for (int i = 0; i < 32; i++) cyc(0, 0, 32'h1000_0000 + i, 1, 0);
    chk("ovf full", full, 1);
    chk("ovf count32", count, 32);
    chk("ovf not yet", overflow, 0);
    cyc(0, 0, 32'hDEADBEEF, 1, 0);
    chk("ovf flag", overflow, 1);
    chk("ovf received", received, 33);
    chk("ovf count kept", count, 32);
    chk("ovf busy drain", busy, 1);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk($sformatf("ovf rd%0d valid", i), rd_valid, 1);
      chk($sformatf("ovf rd%0d data", i), rd_data, 32'h1000_0000 + i);
    end
    chk("ovf empty", empty, 1);
    step();
    chk("ovf done", done, 1);
    chk("ovf busy idle", busy, 0);
    chk("ovf sticky", overflow, 1);
    step();
    chk("ovf done pulse", done, 0);
    chk("ovf sticky2", overflow, 1);

    // Full FIFO with concurrent read: the 33rd write is accepted.
    cyc(1, 6'd33, 0, 0, 0);
    chk("cr overflow cleared", overflow, 0);
    chk("cr received cleared", received, 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 32'h2000_0000 + i, 1, 0);
    chk("cr full", full, 1);
    cyc(0, 0, 32'h2000_0020, 1, 1);
    chk("cr rd_valid", rd_valid, 1);
    chk("cr first word", rd_data, 32'h2000_0000);
    chk("cr overflow", overflow, 0);
    chk("cr count", count, 32);
    chk("cr received", received, 33);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk($sformatf("cr rd%0d data", i), rd_data, 32'h2000_0001 + i);
    end
    step();
    chk("cr done", done, 1);
    chk("cr overflow end", overflow, 0);

    // Watchdog timeout with TIMEOUT_CYCLES=16, then an empty read.
    cyc(1, 6'd3, 0, 0, 0);
    step();
    step();
    cyc(0, 0, 32'h3F80_0000, 1, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("to early%0d", i), timeout, 0);
    end
    step();
    chk("to flag", timeout, 1);
    chk("to busy drain", busy, 1);
    chk("to received", received, 1);
    chk("to count", count, 1);
    cyc(0, 0, 0, 0, 1);
    chk("to rd_valid", rd_valid, 1);
    chk("to rd_data", rd_data, 32'h3F80_0000);
    step();
    chk("to done", done, 1);
    chk("to busy idle", busy, 0);
    chk("to sticky", timeout, 1);
    cyc(0, 0, 0, 0, 1);
    chk("empty rd_valid", rd_valid, 0);
    chk("empty rd_data hold", rd_data, 32'h3F80_0000);

    // Reset in the middle of a job.
    cyc(1, 6'd3, 0, 0, 0);
    cyc(0, 0, 32'hAAAA_0001, 1, 0);
    cyc(0, 0, 32'hAAAA_0002, 1, 0);
    chk("mr count2", count, 2);
    #3 rst = 1'b1;
    #1;
    chk("mr count", count, 0);
    chk("mr busy", busy, 0);
    chk("mr empty", empty, 1);
    chk("mr received", received, 0);
    chk("mr timeout", timeout, 0);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mr no done%0d", i), done, 0);
    end
    cyc(1, 6'd1, 0, 0, 0);
    cyc(0, 0, 32'hBBBB_0003, 1, 0);
    chk("mr2 received", received, 1);
    chk("mr2 count", count, 1);
    chk("mr2 busy", busy, 1);
    cyc(0, 0, 0, 0, 1);
    chk("mr2 rd_data", rd_data, 32'hBBBB_0003);
    step();
    chk("mr2 done", done, 1);
    chk("mr2 busy idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
- Consumer-side counterpart to the mac write port.
- Captures each completed mac result (result_o qualified by the controller's load_result strobe) into an internal result FIFO, counts results against an expected job length, and exposes a registered read port to downstream logic or the host.
- Flags dropped results (overflow) and a stalled mac (watchdog timeout), and pulses done once a job's results have been fully drained.

Parameters:
- DATA_WIDTH, 32, width of one result word (IEEE-754 single).
- ADDR_LINES, 5, FIFO address width; depth DEPTH = 2^ADDR_LINES = 32.
- TIMEOUT_CYCLES, 4096, idle cycles allowed between results in COLLECT; 0 disables the watchdog.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse that begins a job.
- expected_i  in  ADDR_LINES+1  job length, sampled on an accepted start_i.
- result_i  in  DATA_WIDTH  mac result word, valid while result_valid_i=1.
- result_valid_i  in  1  result strobe (mac load_result).
- rd_en_i  in  1  read request.
- rd_data_o  out  DATA_WIDTH  read data, registered.
- rd_valid_o  out  1  rd_data_o valid this cycle.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO holds DEPTH words.
- count_o  out  ADDR_LINES+1  FIFO occupancy, 0..DEPTH.
- received_o  out  ADDR_LINES+1  results seen this job, including dropped ones.
- busy_o  out  1  state is COLLECT or DRAIN.
- done_o  out  1  one-cycle job-complete pulse.
- overflow_o  out  1  sticky: a result was dropped this job.
- timeout_o  out  1  sticky: watchdog expired this job.

Behaviour:
- Reset (asynchronous, any state):
  - pointers, count_o and received_o = 0; empty_o=1.
  - full_o, rd_valid_o, busy_o, done_o, overflow_o, timeout_o = 0; rd_data_o = 0.
  - state = IDLE.
  - Reset mid-job aborts the job with no done_o; FIFO contents are discarded.
- FIFO:
  - Circular buffer with ADDR_LINES-bit pointers that wrap at DEPTH; count_o tracks occupancy.
  - Read accepted when rd_en_i=1 and count_o>0. rd_data_o = head word on the next edge; rd_valid_o=1 for exactly that cycle. Latency is 1 cycle.
  - rd_en_i on an empty FIFO is ignored: rd_valid_o=0, rd_data_o holds.
  - Reads are legal in every state.
  - Write accepted when result_valid_i=1, state=COLLECT, and (count_o<DEPTH or a read is accepted the same cycle).
  - Simultaneous accepted read+write: count unchanged; on a full FIFO no overflow occurs.
  - Write into an empty FIFO: the word is readable from the next cycle.
- States:
  - IDLE:
    - start_i=1 and expected_i!=0: latch expected; clear received_o, overflow_o, timeout_o and the watchdog; go to COLLECT.
    - start_i with expected_i=0 is ignored.
    - result_valid_i is ignored.
  - COLLECT:
    - Each result_valid_i increments received_o, whether written or dropped.
    - A dropped result (FIFO full, no concurrent read) sets overflow_o.
    - The edge where received_o reaches expected goes to DRAIN.
    - Watchdog counter clears on each result_valid_i and otherwise increments. At TIMEOUT_CYCLES (nonzero) it sets timeout_o and goes to DRAIN.
    - start_i is ignored.
  - DRAIN:
    - result_valid_i and start_i are ignored.
    - When count_o=0: go to IDLE and assert done_o for one cycle, registered, in the first IDLE cycle.
    - If the FIFO is already empty on entry, done_o follows one cycle later.
- Sticky flags hold until the next accepted start_i or reset.
- Arithmetic: received_o saturates at 2^(ADDR_LINES+1)-1; all counters are unsigned.

Test Plan:
- Reset: assert rst_i mid-clock -> immediately empty_o=1, count_o=0, busy_o=0, rd_valid_o=0, done_o/overflow_o/timeout_o=0.
- Normal job:
  - Stimulus: start_i with expected_i=3; results 0xC0A00000, 0xC094F72D, 0xC089EE59 spaced 5 cycles; then 3 back-to-back reads.
  - Response: received_o=3 and DRAIN after the third strobe; rd_data_o returns the words in that order, each with rd_valid_o one cycle after rd_en_i; done_o pulses once after the last read; busy_o=0.
- Overflow:
  - Stimulus: expected_i=33, no reads.
  - Response: 32 words stored, full_o=1; 33rd dropped, overflow_o=1, received_o=33, DRAIN. After 32 reads: done_o=1, overflow_o stays 1.
- Full with concurrent read: fill 32 words, then issue the 33rd result with rd_en_i the same cycle -> write accepted, overflow_o=0, count_o=32, the first word is read out.
- Timeout and empty read:
  - Stimulus: TIMEOUT_CYCLES=16, expected_i=3, one result then silence.
  - Response: timeout_o=1 sixteen cycles after the result, DRAIN; one read -> done_o. A further rd_en_i on empty gives rd_valid_o=0.
- Reset mid-job: rst_i after 2 of 3 results -> count_o=0, busy_o=0, no done_o; a later start_i with expected_i=1 plus one result completes normally.
